// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the 16-bit core fetch path: instruction width,
// PC step, fetch FSM encodings and the default reset PC.
package instr_fetch_unit_pkg;

    localparam int ILEN = 16;
    localparam logic [ILEN-1:0] PC_STEP          = 16'd2;
    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Opcode field of an instruction word, for decode-side users of the package.
    function automatic logic [3:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_gen.sv
// PC register with next-PC selection (redirect / advance / hold) and the
// implemented-memory range checks for the current PC and a redirect target.
module instr_fetch_unit_pc_gen
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IMEM_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [ILEN-1:0] redirect_target,
    input  logic            advance,
    output logic [ILEN-1:0] pc,
    output logic            pc_in_range,
    output logic            target_in_range
);

    logic [ILEN-1:0] target_aligned;
    logic [ILEN-1:0] pc_nxt;
    logic            unused_target_b0;

    // Word index must fall inside the implemented memory depth.
    function automatic logic word_in_range(input logic [ILEN-1:0] byte_addr);
        return {17'd0, byte_addr[ILEN-1:1]} < $unsigned(IMEM_WORDS);
    endfunction

    // Targets are halfword aligned; bit 0 of the requested target is dropped.
    assign target_aligned   = {redirect_target[ILEN-1:1], 1'b0};
    assign unused_target_b0 = redirect_target[0];

    assign pc_in_range     = word_in_range(pc);
    assign target_in_range = word_in_range(target_aligned);

    // Next-PC select: redirect wins over sequential advance; otherwise hold.
    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = target_aligned;
        end else if (advance) begin
            pc_nxt = pc + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: FSM, instruction register and valid/ready handoff to decode.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | fetching disabled; PC frozen unless redirected
//  ST_RUN   | one fetch per cycle while the IR slot is free
//  ST_FAULT | PC left implemented memory; waits for an in-range redirect
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IMEM_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [ILEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [ILEN-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] ir,
    output logic [ILEN-1:0] ir_pc,
    output logic [ILEN-1:0] ir_pc_next,
    output logic            fetch_fault
);

    fetch_state_e    state, state_nxt;
    logic [ILEN-1:0] pc;
    logic            pc_in_range;
    logic            target_in_range;
    logic            slot_free;
    logic            do_fetch;
    logic            clr_valid;
    logic            set_fault;

    instr_fetch_unit_pc_gen #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (do_fetch),
        .pc              (pc),
        .pc_in_range     (pc_in_range),
        .target_in_range (target_in_range)
    );

    assign imem_addr = pc;
    assign slot_free = !if_valid || if_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle datapath controls; a redirect overrides everything.
    always_comb begin
        state_nxt = state;
        do_fetch  = 1'b0;
        clr_valid = slot_free;
        set_fault = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fetch_en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!fetch_en) begin
                    state_nxt = ST_IDLE;
                end else if (!pc_in_range) begin
                    state_nxt = ST_FAULT;
                    set_fault = 1'b1;
                end else if (slot_free) begin
                    do_fetch = 1'b1;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (redirect_valid) begin
            do_fetch  = 1'b0;
            set_fault = 1'b0;
            clr_valid = 1'b1;
            // Only an in-range target may pull the unit out of FAULT.
            if (state == ST_FAULT && !target_in_range) begin
                state_nxt = ST_FAULT;
            end else begin
                state_nxt = fetch_en ? ST_RUN : ST_IDLE;
            end
        end
    end

    // Instruction register and valid flag; ir stays stable until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= '0;
            ir_pc      <= '0;
            ir_pc_next <= PC_STEP;
            if_valid   <= 1'b0;
        end else if (do_fetch) begin
            ir         <= imem_instr;
            ir_pc      <= pc;
            ir_pc_next <= pc + PC_STEP;
            if_valid   <= 1'b1;
        end else if (clr_valid) begin
            if_valid   <= 1'b0;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
        end else if (set_fault) begin
            fetch_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (256-word and 32768-word memory)
// share stimulus; a reference model is compared every cycle, plus literal checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic        if_ready = 1'b0;

    logic [15:0] addr_s, instr_s, ir_s, irpc_s, irnx_s;
    logic        v_s, flt_s;
    logic [15:0] addr_b, instr_b, ir_b, irpc_b, irnx_b;
    logic        v_b, flt_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(16'h0000), .IMEM_WORDS(256)) dut_s (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(addr_s),
        .imem_instr(instr_s), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .if_valid(v_s), .if_ready(if_ready),
        .ir(ir_s), .ir_pc(irpc_s), .ir_pc_next(irnx_s), .fetch_fault(flt_s)
    );

    instr_fetch_unit #(.RESET_PC(16'h0000), .IMEM_WORDS(32768)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(addr_b),
        .imem_instr(instr_b), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .if_valid(v_b), .if_ready(if_ready),
        .ir(ir_b), .ir_pc(irpc_b), .ir_pc_next(irnx_b), .fetch_fault(flt_b)
    );

    // Memory contents derived from the word index, so any depth is available.
    function automatic logic [15:0] mem_word(input logic [15:0] byte_addr);
        logic [15:0] idx;
        idx = {1'b0, byte_addr[15:1]};
        return (idx * 16'd937) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mem_at(input int n);
        return mem_word(16'(n * 2));
    endfunction

    assign instr_s = mem_word(addr_s);
    assign instr_b = mem_word(addr_b);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural view of one fetch unit.
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_FAULT = 2'd2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] irpc;
        logic [15:0] irnx;
        logic        v;
        logic        flt;
        logic [1:0]  st;
    } mstate_t;

    localparam mstate_t MS_RESET = '{pc: 16'h0000, ir: 16'h0000, irpc: 16'h0000,
                                     irnx: 16'h0002, v: 1'b0, flt: 1'b0, st: M_IDLE};

    function automatic mstate_t model_next(input mstate_t s, input int words, input logic fe,
                                           input logic rv, input logic rdy, input logic [15:0] tgt);
        mstate_t n;
        logic    slot_free, pc_ok, tgt_ok;
        n = s;
        slot_free = !s.v || rdy;
        pc_ok  = int'(s.pc / 16'd2) < words;
        tgt_ok = int'(tgt / 16'd2) < words;
        if (rv) begin
            n.pc = tgt & 16'hFFFE;
            n.v  = 1'b0;
            if (!(s.st == M_FAULT && !tgt_ok)) n.st = fe ? M_RUN : M_IDLE;
        end else if (s.st == M_RUN && fe && pc_ok && slot_free) begin
            n.ir   = mem_word(s.pc);
            n.irpc = s.pc;
            n.irnx = s.pc + 16'd2;
            n.v    = 1'b1;
            n.pc   = s.pc + 16'd2;
        end else begin
            if (slot_free) n.v = 1'b0;
            if (s.st == M_IDLE && fe) n.st = M_RUN;
            else if (s.st == M_RUN && !fe) n.st = M_IDLE;
            else if (s.st == M_RUN && !pc_ok) begin
                n.st  = M_FAULT;
                n.flt = 1'b1;
            end
        end
        return n;
    endfunction

    mstate_t ms_s, ms_b;

    // Advance the model alongside the DUTs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_s <= MS_RESET;
            ms_b <= MS_RESET;
        end else begin
            ms_s <= model_next(ms_s, 256, fetch_en, redirect_valid, if_ready, redirect_target);
            ms_b <= model_next(ms_b, 32768, fetch_en, redirect_valid, if_ready, redirect_target);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("s_imem_addr",   addr_s,        ms_s.pc);
        chk("s_if_valid",    16'(v_s),      16'(ms_s.v));
        chk("s_ir",          ir_s,          ms_s.ir);
        chk("s_ir_pc",       irpc_s,        ms_s.irpc);
        chk("s_ir_pc_next",  irnx_s,        ms_s.irnx);
        chk("s_fetch_fault", 16'(flt_s),    16'(ms_s.flt));
        chk("b_imem_addr",   addr_b,        ms_b.pc);
        chk("b_if_valid",    16'(v_b),      16'(ms_b.v));
        chk("b_ir",          ir_b,          ms_b.ir);
        chk("b_ir_pc",       irpc_b,        ms_b.irpc);
        chk("b_ir_pc_next",  irnx_b,        ms_b.irnx);
        chk("b_fetch_fault", 16'(flt_b),    16'(ms_b.flt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rdy_pat;
        rdy_pat = 16'b1011_0010_1110_0101;

        // 1: reset, then continuous fetch with if_ready high
        #1 rst_n = 1'b0;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        repeat (3) cyc();
        chk("lit_rst_valid", 16'(v_s), 16'h0000);
        chk("lit_rst_irnx",  irnx_s,   16'h0002);
        rst_n = 1'b1;
        cyc();
        chk("lit_t1_valid_low_after_1", 16'(v_s), 16'h0000);
        cyc();
        chk("lit_t1_valid_high", 16'(v_s), 16'h0001);
        chk("lit_t1_ir0",        ir_s,     mem_at(0));
        chk("lit_t1_irpc0",      irpc_s,   16'h0000);
        cyc();
        chk("lit_t1_ir1",        ir_s,     mem_at(1));
        chk("lit_t1_irpc1",      irpc_s,   16'h0002);
        cyc();
        chk("lit_t1_irpc2",      irpc_s,   16'h0004);
        cyc();
        chk("lit_t1_ir3",        ir_s,     mem_at(3));

        // 2: stall for 3 cycles on mem[3]
        if_ready = 1'b0;
        repeat (3) cyc();
        chk("lit_t2_ir_held",    ir_s,     mem_at(3));
        chk("lit_t2_irpc_held",  irpc_s,   16'h0006);
        chk("lit_t2_pc_held",    addr_s,   16'h0008);
        if_ready = 1'b1;
        cyc();
        chk("lit_t2_ir4",        ir_s,     mem_at(4));
        chk("lit_t2_irpc4",      irpc_s,   16'h0008);

        // 3: redirect to 0x0015 during a stall
        if_ready = 1'b0;
        cyc();
        redirect_valid = 1'b1;
        redirect_target = 16'h0015;
        cyc();
        chk("lit_t3_pc",         addr_s,   16'h0014);
        chk("lit_t3_valid",      16'(v_s), 16'h0000);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        cyc();
        chk("lit_t3_ir10",       ir_s,     mem_at(10));
        chk("lit_t3_irpc",       irpc_s,   16'h0014);

        // 4: run off the end of the 256-word memory, then recover
        redirect_valid = 1'b1;
        redirect_target = 16'h01FE;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("lit_t4_ir255",      ir_s,     mem_at(255));
        cyc();
        chk("lit_t4_fault",      16'(flt_s), 16'h0001);
        chk("lit_t4_valid",      16'(v_s),   16'h0000);
        chk("lit_t4_pc",         addr_s,     16'h0200);
        chk("lit_t4_big_nofault",16'(flt_b), 16'h0000);
        chk("lit_t4_big_irpc",   irpc_b,     16'h0200);
        cyc();
        chk("lit_t4_pc_hold",    addr_s,     16'h0200);
        redirect_valid = 1'b1;
        redirect_target = 16'h0000;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("lit_t4_ir0",        ir_s,       mem_at(0));
        chk("lit_t4_sticky",     16'(flt_s), 16'h0001);

        // 5: wrap at 0xFFFE on the full-depth instance
        redirect_valid = 1'b1;
        redirect_target = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("lit_t5_irpc",       irpc_b,     16'hFFFE);
        chk("lit_t5_irnx",       irnx_b,     16'h0000);
        cyc();
        chk("lit_t5_irpc_wrap",  irpc_b,     16'h0000);
        chk("lit_t5_nofault",    16'(flt_b), 16'h0000);

        // mixed if_ready pattern from an in-range address
        redirect_valid = 1'b1;
        redirect_target = 16'h0040;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if_ready = rdy_pat[i];
            cyc();
        end

        // fetch_en low, then redirect while idle
        if_ready = 1'b1;
        fetch_en = 1'b0;
        repeat (2) cyc();
        chk("lit_idle_valid",    16'(v_b),   16'h0000);
        redirect_valid = 1'b1;
        redirect_target = 16'h0031;
        cyc();
        redirect_valid = 1'b0;
        chk("lit_idle_redir_pc", addr_b,     16'h0030);
        cyc();
        chk("lit_idle_pc_hold",  addr_b,     16'h0030);
        fetch_en = 1'b1;
        cyc();
        cyc();
        chk("lit_idle_resume",   irpc_b,     16'h0030);

        // 6: async reset in the middle of a stall
        if_ready = 1'b0;
        cyc();
        chk("lit_t6_stalled",    16'(v_b),   16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_t6_valid",      16'(v_b),   16'h0000);
        chk("lit_t6_ir",         ir_b,       16'h0000);
        chk("lit_t6_irpc",       irpc_b,     16'h0000);
        chk("lit_t6_irnx",       irnx_b,     16'h0002);
        chk("lit_t6_pc",         addr_b,     16'h0000);
        chk("lit_t6_fault_clr",  16'(flt_s), 16'h0000);
        cyc();
        rst_n = 1'b1;
        fetch_en = 1'b0;
        repeat (2) cyc();
        chk("lit_t6_idle_valid", 16'(v_b),   16'h0000);
        fetch_en = 1'b1;
        if_ready = 1'b1;
        cyc();
        chk("lit_t6_run_first",  16'(v_b),   16'h0000);
        cyc();
        chk("lit_t6_ir0",        ir_b,       mem_at(0));
        chk("lit_t6_valid_up",   16'(v_b),   16'h0001);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
